// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
// master: fetch_ctrl drives imem_req/imem_addr; slave: imem returns ack/rdata.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, handshakes with variable-latency imem,
// buffers one instruction for D (f_*), applies D redirects, flags timeouts.
// Ports: clk, reset (sync, active-high), imem (fetch_ctrl_if.master),
// d_stall/d_redirect/d_target from D, f_valid/f_instr/f_pc/f_pcplus8/f_err out.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    fetch_ctrl_if.master       imem,
    input  logic               d_stall,
    input  logic               d_redirect,
    input  logic [31:0]        d_target,
    output logic               f_valid,
    output logic [31:0]        f_instr,
    output logic [31:0]        f_pc,
    output logic [31:0]        f_pcplus8,
    output logic               f_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_IDLE = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [31:0]      pc, pc_n;
    logic             pend_valid, pend_valid_n;
    logic [31:0]      pend_target, pend_target_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             f_valid_n;
    logic [31:0]      f_instr_n;
    logic [31:0]      f_pc_n;
    logic             f_err_n;

    // Request side depends on registered state only.
    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pc;
    assign f_pcplus8      = f_pc + 32'd8;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;
        wait_cnt_n    = wait_cnt;
        f_valid_n     = f_valid;
        f_instr_n     = f_instr;
        f_pc_n        = f_pc;
        f_err_n       = f_err;
        unique case (state)
            S_REQ: begin
                if (imem.imem_ack) begin
                    f_instr_n    = imem.imem_rdata;
                    f_pc_n       = pc;
                    f_valid_n    = 1'b1;
                    wait_cnt_n   = '0;
                    state_n      = S_IDLE;
                    pend_valid_n = 1'b0;
                    // The instruction just returned is the delay slot;
                    // a redirect seen now or earlier steers the next fetch.
                    if (d_redirect)
                        pc_n = d_target;
                    else if (pend_valid)
                        pc_n = pend_target;
                    else
                        pc_n = pc + 32'd4;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                    // Address must stay stable until ack, so park it.
                    if (d_redirect) begin
                        pend_valid_n  = 1'b1;
                        pend_target_n = d_target;
                    end
                    if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_n = S_ERR;
                        f_err_n = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                // pc not yet requested, so retarget it directly.
                if (d_redirect)
                    pc_n = d_target;
                if (!d_stall) begin
                    f_valid_n = 1'b0;
                    state_n   = S_REQ;
                end
            end
            S_ERR: begin
                f_valid_n = 1'b0;
            end
            default: begin
                state_n = S_ERR;
                f_err_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            wait_cnt    <= '0;
            f_valid     <= 1'b0;
            f_instr     <= '0;
            f_pc        <= '0;
            f_err       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_valid  <= pend_valid_n;
            pend_target <= pend_target_n;
            wait_cnt    <= wait_cnt_n;
            f_valid     <= f_valid_n;
            f_instr     <= f_instr_n;
            f_pc        <= f_pc_n;
            f_err       <= f_err_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue scoreboard of expected
// {pc, instr} pairs pushed at ack and popped when f_valid appears.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_stall;
    logic        d_redirect;
    logic [31:0] d_target;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pcplus8;
    logic        f_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;

    fetch_ctrl_if imem ();

    fetch_ctrl #(
        .RESET_PC (32'h0000_3000),
        .TIMEOUT  (16),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (imem.master),
        .d_stall    (d_stall),
        .d_redirect (d_redirect),
        .d_target   (d_target),
        .f_valid    (f_valid),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
        .f_pcplus8  (f_pcplus8),
        .f_err      (f_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        d_stall         = 1'b1;
        d_redirect      = 1'b0;
        d_target        = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, imem.imem_req}, 32'd1);
        check("rst_addr", imem.imem_addr, 32'h3000);
        check("rst_fvalid", {31'b0, f_valid}, 32'd0);
        check("rst_finstr", f_instr, 32'h0);
        check("rst_fpc", f_pc, 32'h0);
        check("rst_ferr", {31'b0, f_err}, 32'd0);
        reset = 1'b0;
    endtask

    // One fetch: ack after 'delay' wait cycles; redirects pulse at
    // wait-cycle index r1c / r2c (index == delay means with the ack).
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int delay, input int r1c,
                         input logic [31:0] r1t, input int r2c,
                         input logic [31:0] r2t);
        logic [63:0] e;
        int n = 0;
        while (!imem.imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i <= delay; i++) begin
            check("req_on", {31'b0, imem.imem_req}, 32'd1);
            check("req_addr", imem.imem_addr, addr);
            check("req_fvalid", {31'b0, f_valid}, 32'd0);
            imem.imem_ack   = (i == delay);
            imem.imem_rdata = (i == delay) ? data : 32'hdead_beef;
            d_redirect      = (i == r1c) || (i == r2c);
            d_target        = (i == r2c) ? r2t : r1t;
            if (i == delay)
                sb.push_back({addr, data});
            @(negedge clk);
        end
        imem.imem_ack = 1'b0;
        d_redirect    = 1'b0;
        check("dlv_fvalid", {31'b0, f_valid}, 32'd1);
        check("dlv_req", {31'b0, imem.imem_req}, 32'd0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            cur_pc    = e[63:32];
            cur_instr = e[31:0];
            check("dlv_instr", f_instr, cur_instr);
            check("dlv_pc", f_pc, cur_pc);
            check("dlv_pc8", f_pcplus8, cur_pc + 32'd8);
        end
    endtask

    // Hold D for 'stalls' cycles, then consume (optionally redirecting).
    task automatic consume(input int stalls, input logic redir,
                           input logic [31:0] tgt);
        for (int i = 0; i < stalls; i++) begin
            d_stall = 1'b1;
            @(negedge clk);
            check("stl_fvalid", {31'b0, f_valid}, 32'd1);
            check("stl_req", {31'b0, imem.imem_req}, 32'd0);
            check("stl_instr", f_instr, cur_instr);
            check("stl_pc", f_pc, cur_pc);
        end
        d_stall    = 1'b0;
        d_redirect = redir;
        d_target   = tgt;
        @(negedge clk);
        d_redirect = 1'b0;
        d_stall    = 1'b1;
        check("cns_fvalid", {31'b0, f_valid}, 32'd0);
    endtask

    initial begin
        do_reset();

        fetch(32'h3000, 32'h3c01_0001, 0, -1, 0, -1, 0);
        consume(0, 1'b0, 0);
        fetch(32'h3004, 32'h2421_0001, 3, -1, 0, -1, 0);
        consume(5, 1'b0, 0);
        fetch(32'h3008, 32'h1000_003d, 0, -1, 0, -1, 0);
        consume(0, 1'b0, 0);

        // Redirect while the delay-slot request is outstanding.
        fetch(32'h300c, 32'h0000_0000, 2, 1, 32'h3100, -1, 0);
        consume(0, 1'b0, 0);
        fetch(32'h3100, 32'h1000_ffff, 0, -1, 0, -1, 0);
        consume(0, 1'b0, 0);

        // Redirect while the delay slot sits in the buffer (IDLE).
        fetch(32'h3104, 32'h2000_0001, 1, -1, 0, -1, 0);
        consume(2, 1'b1, 32'h3100);
        fetch(32'h3100, 32'h1000_ffff, 0, -1, 0, -1, 0);
        consume(0, 1'b0, 0);

        // Redirect coincident with the delay-slot ack.
        fetch(32'h3104, 32'h2000_0002, 2, 2, 32'h3100, -1, 0);
        consume(0, 1'b0, 0);

        // Two redirects during one request: latest wins.
        fetch(32'h3100, 32'h2000_0003, 3, 0, 32'h3100, 2, 32'h3200);
        consume(0, 1'b0, 0);
        fetch(32'h3200, 32'h2000_0004, 0, -1, 0, -1, 0);

        // Wrap of pc+4 and f_pc+8 at the top of the address space.
        consume(0, 1'b1, 32'hffff_fffc);
        fetch(32'hffff_fffc, 32'h2000_0005, 1, -1, 0, -1, 0);
        consume(0, 1'b0, 0);
        fetch(32'h0000_0000, 32'h2000_0006, 0, -1, 0, -1, 0);
        consume(0, 1'b0, 0);

        // Timeout: no ack for TIMEOUT request cycles.
        for (int i = 0; i < 16; i++) begin
            check("to_req", {31'b0, imem.imem_req}, 32'd1);
            check("to_err0", {31'b0, f_err}, 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            d_redirect = (i == 1);
            d_stall    = (i == 2);
            d_target   = 32'h3300;
            check("err_flag", {31'b0, f_err}, 32'd1);
            check("err_req", {31'b0, imem.imem_req}, 32'd0);
            check("err_fvalid", {31'b0, f_valid}, 32'd0);
            @(negedge clk);
        end
        d_redirect = 1'b0;

        do_reset();
        fetch(32'h3000, 32'h3c01_0001, 1, -1, 0, -1, 0);
        consume(0, 1'b0, 0);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
